// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizes and write-side state encoding for the 8x32 FIFO
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int COUNT_WIDTH    = DEF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WRITE    = 2'b01,
        WR_ERROR = 2'b10
    } wr_state_t;

endpackage

// File: rtl/fifo_wr_decoder.sv
// rtl/fifo_wr_decoder.sv - one-hot load enables for the entry addressed by the write pointer
module fifo_wr_decoder
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic [ADDR_WIDTH-1:0] ptr,
    input  logic                  en,
    output logic [DEPTH-1:0]      load
);

    always_comb begin
        load      = '0;
        load[ptr] = en;
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - FIFO write side: storage, write pointer, count, handshake (option: FIFO_WR_ALMOST_FULL_EN)
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL   = DEPTH - 1
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        rd_pop,
    output logic [ADDR_WIDTH-1:0]       wr_ptr,
    output logic [ADDR_WIDTH:0]         count,
    output logic                        full,
    output logic                        empty,
    output logic                        wr_ack,
    output logic                        wr_err,
    output logic [DATA_WIDTH*DEPTH-1:0] mem_flat
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    output logic                        almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    wr_state_t             state;
    wr_state_t             state_next;
    logic                  accept;
    logic                  pop;
    logic [DEPTH-1:0]      load;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    // Full always rejects, even when the read side frees a slot in the same cycle.
    assign accept = we && !full;
    assign pop    = rd_pop && !empty;

`ifdef FIFO_WR_ALMOST_FULL_EN
    assign almost_full = (count >= (ADDR_WIDTH + 1)'(AF_LEVEL));
`endif

    always_comb begin
        state_next = IDLE;
        if (we) begin
            state_next = full ? WR_ERROR : WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign wr_ack = (state == WRITE);
    assign wr_err = (state == WR_ERROR);

    fifo_wr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_decoder (
        .ptr  (wr_ptr),
        .en   (accept),
        .load (load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem[i] <= '0;
            end else if (load[i]) begin
                mem[i] <= din;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - scoreboard bench for fifo_write_ctrl with a queue-based reference model
module tb_fifo_write_ctrl;

    typedef struct packed {
        logic [3:0]   cnt;
        logic [2:0]   ptr;
        logic         ack;
        logic         err;
        logic         af;
        logic [255:0] mem;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         we;
    logic [31:0]  din;
    logic         rd_pop;
    logic [2:0]   wr_ptr;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         wr_ack;
    logic         wr_err;
    logic [255:0] mem_flat;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic         almost_full;
`endif

    fifo_write_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .din      (din),
        .rd_pop   (rd_pop),
        .wr_ptr   (wr_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .mem_flat (mem_flat)
`ifdef FIFO_WR_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model: contents by slot, pointer and occupancy as plain integers
    logic [31:0] m_mem[8];
    int          m_ptr;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic s_we, input logic [31:0] s_din, input logic s_pop, input logic s_rst);
        exp_t e;
        int   accepted;
        int   popped;
        we     = s_we;
        din    = s_din;
        rd_pop = s_pop;
        reset  = s_rst;
        if (s_rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
            m_ptr = 0;
            m_cnt = 0;
            e.ack = 1'b0;
            e.err = 1'b0;
        end else begin
            accepted = (s_we && m_cnt < 8) ? 1 : 0;
            popped   = (s_pop && m_cnt > 0) ? 1 : 0;
            if (accepted == 1) begin
                m_mem[m_ptr] = s_din;
                m_ptr = (m_ptr + 1) % 8;
            end
            m_cnt = m_cnt + accepted - popped;
            e.ack = (accepted == 1);
            e.err = s_we && (accepted == 0);
        end
        e.cnt = 4'(m_cnt);
        e.ptr = 3'(m_ptr);
        e.af  = (m_cnt >= 7);
        for (int i = 0; i < 8; i++) e.mem[i*32 +: 32] = m_mem[i];
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // monitor: every edge is a response cycle; compare once the edge has settled
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count",  32'(count),  32'(e.cnt));
                check("wr_ptr", 32'(wr_ptr), 32'(e.ptr));
                check("full",   32'(full),   32'(e.cnt == 4'd8));
                check("empty",  32'(empty),  32'(e.cnt == 4'd0));
                check("wr_ack", 32'(wr_ack), 32'(e.ack));
                check("wr_err", 32'(wr_err), 32'(e.err));
`ifdef FIFO_WR_ALMOST_FULL_EN
                check("almost_full", 32'(almost_full), 32'(e.af));
`endif
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("entry%0d", i), mem_flat[i*32 +: 32], e.mem[i*32 +: 32]);
                end
            end
        end
    end

    initial begin
        int budget;
        we = 1'b0; din = 32'h0; rd_pop = 1'b0; reset = 1'b1;
        m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;

        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
        step(1'b1, 32'hCAFE_0002, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hB000_0003, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2);
        end
        we = 1'b0; rd_pop = 1'b0; reset = 1'b0;

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
